// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming SECDED codec: mode encodings and
// the bit-placement helpers used by both pipeline stages.
package hamming_pkg;

  // Helpers work on a fixed maximum width so any P_BITS up to MAX_P_BITS fits.
  localparam int MAX_P_BITS = 7;
  localparam int MAX_CW     = 2 ** MAX_P_BITS;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  function automatic logic is_pow2(input int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  function automatic logic [MAX_CW-1:0] scatter(input logic [MAX_CW-1:0] data, input int cw);
    logic [MAX_CW-1:0] word;
    int n;
    word = '0;
    n    = 0;
    for (int i = 3; i < MAX_CW; i++) begin
      if ((i < cw) && !is_pow2(i)) begin
        word[i] = data[n];
        n       = n + 1;
      end
    end
    return word;
  endfunction

  function automatic logic [MAX_CW-1:0] gather(input logic [MAX_CW-1:0] word, input int cw);
    logic [MAX_CW-1:0] data;
    int n;
    data = '0;
    n    = 0;
    for (int i = 3; i < MAX_CW; i++) begin
      if ((i < cw) && !is_pow2(i)) begin
        data[n] = word[i];
        n       = n + 1;
      end
    end
    return data;
  endfunction

  function automatic logic [MAX_P_BITS-1:0] syndrome(input logic [MAX_CW-1:0] word, input int cw);
    logic [MAX_P_BITS-1:0] s;
    s = '0;
    for (int i = 1; i < MAX_CW; i++) begin
      if ((i < cw) && word[i]) begin
        s = s ^ MAX_P_BITS'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational second half of the codec: inserts parity bits for encode, or
// classifies/corrects a received codeword and extracts its data for decode.
module hamming_secded_core
  import hamming_pkg::*;
#(
  parameter int P_BITS = 3,
  parameter int CW     = 2 ** P_BITS
) (
  input  mode_e             mode_i,
  input  logic [CW-1:0]     word_i,
  input  logic [P_BITS-1:0] syn_i,
  input  logic              par_i,
  output logic [CW-1:0]     word_o,
  output logic              sec_o,
  output logic              ded_o,
  output logic [P_BITS-1:0] syn_o
);

  logic [CW-1:0] fixed_s;

  // Encode: syndrome of the scattered word is exactly the parity bit vector.
  always_comb begin
    fixed_s = word_i;
    word_o  = '0;
    sec_o   = 1'b0;
    ded_o   = 1'b0;
    syn_o   = '0;
    case (mode_i)
      MODE_ENC: begin
        for (int k = 0; k < P_BITS; k++) begin
          fixed_s[2 ** k] = syn_i[k];
        end
        fixed_s[0] = ^fixed_s[CW-1:1];
        word_o     = fixed_s;
      end
      MODE_DEC: begin
        if (par_i) begin
          fixed_s[syn_i] = ~fixed_s[syn_i];
          sec_o          = 1'b1;
        end else if (syn_i != '0) begin
          ded_o = 1'b1;
        end else begin
          sec_o = 1'b0;
          ded_o = 1'b0;
        end
        word_o = CW'(gather(MAX_CW'(fixed_s), CW));
        syn_o  = syn_i;
      end
      default: begin
        word_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined SECDED codec with valid/ready flow control and
// saturating counters of delivered SEC/DED events.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int P_BITS    = 3,
  parameter int CW        = 2 ** P_BITS,
  parameter int K         = 2 ** P_BITS - P_BITS - 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [CW-1:0]        in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_word,
  output logic                 out_mode,
  output logic                 out_sec,
  output logic                 out_ded,
  output logic [P_BITS-1:0]    out_syndrome,
  input  logic                 clr_counts,
  output logic [CNT_WIDTH-1:0] sec_count,
  output logic [CNT_WIDTH-1:0] ded_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 adv_s;
  logic                 out_fire_s;
  logic [CW-1:0]        s1_word_d, s1_word_q;
  logic [P_BITS-1:0]    s1_syn_d, s1_syn_q;
  logic                 s1_par_d, s1_par_q;
  logic                 s1_valid_q;
  mode_e                s1_mode_q;
  logic [CW-1:0]        core_word_s;
  logic                 core_sec_s, core_ded_s;
  logic [P_BITS-1:0]    core_syn_s;
  logic                 out_valid_q, out_mode_q, out_sec_q, out_ded_q;
  logic [CW-1:0]        out_word_q;
  logic [P_BITS-1:0]    out_syn_q;
  logic [CNT_WIDTH-1:0] sec_count_d, sec_count_q, ded_count_d, ded_count_q;

  // One advance signal moves the whole pipeline, so ready never depends on in_valid.
  assign adv_s      = !out_valid_q || out_ready;
  assign in_ready   = adv_s;
  assign out_fire_s = out_valid_q && out_ready;

  // Stage-1 datapath: scatter encode data, then syndrome/parity of the registered word.
  always_comb begin
    if (mode_e'(in_mode) == MODE_ENC) begin
      s1_word_d = CW'(scatter(MAX_CW'(in_word[K-1:0]), CW));
    end else begin
      s1_word_d = in_word;
    end
    s1_syn_d = P_BITS'(syndrome(MAX_CW'(s1_word_d), CW));
    s1_par_d = ^s1_word_d;
  end

  // Stage-1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_ENC;
      s1_word_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (adv_s) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode_e'(in_mode);
        s1_word_q <= s1_word_d;
        s1_syn_q  <= s1_syn_d;
        s1_par_q  <= s1_par_d;
      end
    end
  end

  hamming_secded_core #(
    .P_BITS (P_BITS),
    .CW     (CW)
  ) u_core (
    .mode_i (s1_mode_q),
    .word_i (s1_word_q),
    .syn_i  (s1_syn_q),
    .par_i  (s1_par_q),
    .word_o (core_word_s),
    .sec_o  (core_sec_s),
    .ded_o  (core_ded_s),
    .syn_o  (core_syn_s)
  );

  // Stage-2 (output) registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_mode_q  <= 1'b0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_syn_q   <= '0;
    end else if (adv_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_word_q <= core_word_s;
        out_mode_q <= s1_mode_q;
        out_sec_q  <= core_sec_s;
        out_ded_q  <= core_ded_s;
        out_syn_q  <= core_syn_s;
      end
    end
  end

  // Counter next-state: clear wins over a same-cycle increment; saturate at all-ones.
  always_comb begin
    sec_count_d = sec_count_q;
    ded_count_d = ded_count_q;
    if (clr_counts) begin
      sec_count_d = '0;
      ded_count_d = '0;
    end else begin
      if (out_fire_s && out_sec_q && (sec_count_q != '1)) begin
        sec_count_d = sec_count_q + CNT_ONE;
      end else begin
        sec_count_d = sec_count_q;
      end
      if (out_fire_s && out_ded_q && (ded_count_q != '1)) begin
        ded_count_d = ded_count_q + CNT_ONE;
      end else begin
        ded_count_d = ded_count_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count_q <= '0;
      ded_count_q <= '0;
    end else begin
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_word     = out_word_q;
  assign out_mode     = out_mode_q;
  assign out_sec      = out_sec_q;
  assign out_ded      = out_ded_q;
  assign out_syndrome = out_syn_q;
  assign sec_count    = sec_count_q;
  assign ded_count    = ded_count_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Scoreboard bench for hamming_secded_codec (P_BITS=3, small 3-bit counters so
// saturation is reachable).
module tb_hamming_secded_codec;

  localparam int P_BITS    = 3;
  localparam int CW        = 8;
  localparam int CNT_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, in_ready, in_mode;
  logic [CW-1:0]        in_word;
  logic                 out_valid, out_ready, out_mode, out_sec, out_ded;
  logic [CW-1:0]        out_word;
  logic [P_BITS-1:0]    out_syndrome;
  logic                 clr_counts;
  logic [CNT_WIDTH-1:0] sec_count, ded_count;

  typedef struct {
    logic [7:0] word;
    logic       mode;
    logic       sec;
    logic       ded;
    logic [2:0] syn;
  } exp_t;

  exp_t                 sb[$];
  exp_t                 mon_e;
  int                   n_checks = 0;
  int                   n_pass   = 0;
  logic [CNT_WIDTH-1:0] exp_sec  = '0;
  logic [CNT_WIDTH-1:0] exp_ded  = '0;

  hamming_secded_codec #(
    .P_BITS    (P_BITS),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_mode     (out_mode),
    .out_sec      (out_sec),
    .out_ded      (out_ded),
    .out_syndrome (out_syndrome),
    .clr_counts   (clr_counts),
    .sec_count    (sec_count),
    .ded_count    (ded_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  function automatic exp_t mk(input logic [7:0] w, input logic m, input logic s,
                              input logic d, input logic [2:0] y);
    exp_t e;
    e.word = w; e.mode = m; e.sec = s; e.ded = d; e.syn = y;
    return e;
  endfunction

  // Reference SECDED(8,4) written out from the parity-check equations.
  function automatic logic [7:0] m_encode(input logic [3:0] d);
    logic [7:0] c;
    c    = 8'h00;
    c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic exp_t m_expect(input logic m, input logic [7:0] w);
    logic [2:0] s;
    logic [7:0] f;
    logic       sec, ded;
    if (!m) return mk(m_encode(w[3:0]), 1'b0, 1'b0, 1'b0, 3'd0);
    s   = {w[4] ^ w[5] ^ w[6] ^ w[7], w[2] ^ w[3] ^ w[6] ^ w[7], w[1] ^ w[3] ^ w[5] ^ w[7]};
    f   = w;
    sec = 1'b0;
    ded = 1'b0;
    if (^w) begin
      f[s] = ~f[s];
      sec  = 1'b1;
    end else if (s != 3'd0) begin
      ded = 1'b1;
    end
    return mk({4'h0, f[7], f[6], f[5], f[3]}, 1'b1, sec, ded, s);
  endfunction

  // Monitor: compare head of scoreboard while valid; pop and count on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() == 0) begin
        check_eq("no_stale_out", {31'd0, out_valid}, 32'd0);
      end else if (out_valid) begin
        mon_e = sb[0];
        check_eq("out_word", {24'd0, out_word}, {24'd0, mon_e.word});
        check_eq("out_mode", {31'd0, out_mode}, {31'd0, mon_e.mode});
        check_eq("out_sec", {31'd0, out_sec}, {31'd0, mon_e.sec});
        check_eq("out_ded", {31'd0, out_ded}, {31'd0, mon_e.ded});
        check_eq("out_syndrome", {29'd0, out_syndrome}, {29'd0, mon_e.syn});
        if (out_ready) begin
          void'(sb.pop_front());
          if (mon_e.sec && exp_sec != 3'h7) exp_sec = exp_sec + 3'd1;
          if (mon_e.ded && exp_ded != 3'h7) exp_ded = exp_ded + 3'd1;
        end
      end
      if (clr_counts) begin
        exp_sec = '0;
        exp_ded = '0;
      end
    end
  end

  // Present one word (called at posedge+1); returns just after its handshake edge.
  task automatic send(input logic m, input logic [7:0] w, input exp_t e);
    in_valid = 1'b1;
    in_mode  = m;
    in_word  = w;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check_eq("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain_left", sb.size(), 32'd0);
  endtask

  logic [16:0] stream_tbl [6];

  initial begin
    // {mode, data nibble, mask}: decode words are encode(data)^mask, encode words carry junk upper bits
    stream_tbl = '{{1'b0, 8'h05, 8'hA0}, {1'b1, 8'h03, 8'h04}, {1'b0, 8'h0F, 8'h50},
                   {1'b1, 8'h09, 8'h00}, {1'b1, 8'h06, 8'h12}, {1'b0, 8'h00, 8'hF0}};
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_word = 8'h00;
    out_ready = 1'b1; clr_counts = 1'b0;
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_word", {24'd0, out_word}, 32'd0);
    check_eq("rst_out_flags", {29'd0, out_mode, out_sec, out_ded}, 32'd0);
    check_eq("rst_out_syndrome", {29'd0, out_syndrome}, 32'd0);
    check_eq("rst_counts", {26'd0, sec_count, ded_count}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(1'b0, 8'h0B, mk(8'hAA, 1'b0, 1'b0, 1'b0, 3'd0));
    in_valid = 1'b0;
    check_eq("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_two", {31'd0, out_valid}, 32'd1);
    drain();

    send(1'b1, 8'hAA, mk(8'h0B, 1'b1, 1'b0, 1'b0, 3'd0));
    send(1'b1, 8'h8A, mk(8'h0B, 1'b1, 1'b1, 1'b0, 3'd5));
    in_valid = 1'b0;
    drain();
    check_eq("sec_cnt_one", {29'd0, sec_count}, 32'd1);
    send(1'b1, 8'hAB, mk(8'h0B, 1'b1, 1'b1, 1'b0, 3'd0));
    send(1'b1, 8'hCA, mk(8'h0D, 1'b1, 1'b0, 1'b1, 3'd3));
    in_valid = 1'b0;
    drain();
    check_eq("sec_cnt_two", {29'd0, sec_count}, {29'd0, exp_sec});
    check_eq("ded_cnt_one", {29'd0, ded_count}, 32'd1);

    // Mixed stream with a 3-cycle sink stall in the middle.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] w;
          w = stream_tbl[i][16] ? (m_encode(stream_tbl[i][11:8]) ^ stream_tbl[i][7:0])
                                : (stream_tbl[i][15:8] | stream_tbl[i][7:0]);
          send(stream_tbl[i][16], w, m_expect(stream_tbl[i][16], w));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("stall_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("stream_sec_cnt", {29'd0, sec_count}, {29'd0, exp_sec});
    check_eq("stream_ded_cnt", {29'd0, ded_count}, {29'd0, exp_ded});

    for (int i = 0; i < 9; i++) send(1'b1, 8'h8A, mk(8'h0B, 1'b1, 1'b1, 1'b0, 3'd5));
    in_valid = 1'b0;
    drain();
    check_eq("sec_cnt_saturated", {29'd0, sec_count}, 32'd7);
    check_eq("sec_cnt_model", {29'd0, sec_count}, {29'd0, exp_sec});

    // Clear lands in the same cycle as the SEC result handshake.
    send(1'b1, 8'h8A, mk(8'h0B, 1'b1, 1'b1, 1'b0, 3'd5));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("clr_cycle_valid", {31'd0, out_valid}, 32'd1);
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    check_eq("clr_wins_sec", {29'd0, sec_count}, 32'd0);
    check_eq("clr_wins_model", {29'd0, sec_count}, {29'd0, exp_sec});
    drain();

    send(1'b1, 8'hCA, mk(8'h0D, 1'b1, 1'b0, 1'b1, 3'd3));
    in_valid = 1'b0;
    drain();
    check_eq("pre_rst_ded", {29'd0, ded_count}, 32'd1);

    // Reset with two words in flight.
    send(1'b0, 8'h03, m_expect(1'b0, 8'h03));
    send(1'b1, 8'h8A, m_expect(1'b1, 8'h8A));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_word", {24'd0, out_word}, 32'd0);
    check_eq("mid_rst_flags", {26'd0, out_mode, out_sec, out_ded, out_syndrome}, 32'd0);
    check_eq("mid_rst_counts", {26'd0, sec_count, ded_count}, 32'd0);
    sb.delete();
    exp_sec = '0;
    exp_ded = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", {31'd0, out_valid}, 32'd0);

    send(1'b0, 8'h06, m_expect(1'b0, 8'h06));
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
